// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin arbiter granting one requester at a time to a single SPI master
module spi_master_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 255
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ-1:0]               req_rd_we,
  input  logic [NUM_REQ*16-1:0]            req_divider,
  input  logic [NUM_REQ-1:0]               req_cpol,
  input  logic [NUM_REQ-1:0]               req_cpha,
  output logic [NUM_REQ-1:0]               ack,
  output logic                             rsp_valid,
  output logic [2:0]                       rsp_id,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rsp_err,
  output logic                             m_enable,
  output logic                             m_rd_we,
  output logic [ADDRESS_WIDTH-1:0]         m_address,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [15:0]                      m_divider,
  output logic                             m_cpol,
  output logic                             m_cpha,
  input  logic                             m_busy,
  input  logic [DATA_WIDTH-1:0]            m_data_read
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESPOND} state_t;
  state_t state;
  logic [2:0] ptr, win, hi_win, lo_win;
  logic hi_found, seen;
  logic [7:0] cnt;
  logic [NUM_REQ-1:0] grant;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [15:0] sel_div;
  logic sel_rw, sel_cpol, sel_cpha;
  // Round-robin: lowest requester above ptr wins, otherwise wrap to the lowest requester overall
  always_comb begin
    hi_win = '0;
    lo_win = '0;
    hi_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) begin
        lo_win = 3'(i);
        if (i > int'(ptr)) begin
          hi_win = 3'(i);
          hi_found = 1'b1;
        end
      end
  end
  assign win = hi_found ? hi_win : lo_win;
  // Extract the winner's payload and one-hot grant from the packed request buses
  always_comb begin
    grant = '0;
    sel_addr = '0;
    sel_data = '0;
    sel_div = '0;
    sel_rw = 1'b0;
    sel_cpol = 1'b0;
    sel_cpha = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win == 3'(i)) begin
        grant[i] = 1'b1;
        sel_addr = req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_div = req_divider[i*16 +: 16];
        sel_rw = req_rd_we[i];
        sel_cpol = req_cpol[i];
        sel_cpha = req_cpha[i];
      end
  end
  // Transaction sequencer; the m_* payload only changes on a grant so it stays stable until RESPOND
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= 3'(NUM_REQ - 1);
      cnt <= '0;
      seen <= 1'b0;
      ack <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      m_enable <= 1'b0;
      m_rd_we <= 1'b0;
      m_address <= '0;
      m_data <= '0;
      m_divider <= '0;
      m_cpol <= 1'b0;
      m_cpha <= 1'b0;
    end else begin
      ack <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          ack <= grant;
          ptr <= win;
          m_address <= sel_addr;
          m_data <= sel_data;
          m_rd_we <= sel_rw;
          m_divider <= sel_div;
          m_cpol <= sel_cpol;
          m_cpha <= sel_cpha;
          state <= LAUNCH;
        end
        LAUNCH: begin
          m_enable <= 1'b1;
          cnt <= '0;
          seen <= 1'b0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (m_busy) begin
          m_enable <= 1'b0;
          state <= WAIT_DONE;
        end else if (cnt == 8'(START_TIMEOUT)) begin
          m_enable <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_id <= ptr;
          rsp_data <= '0;
          rsp_err <= 1'b1;
          state <= RESPOND;
        end else cnt <= cnt + 8'd1;
        WAIT_DONE: if (seen && !m_busy) begin
          rsp_valid <= 1'b1;
          rsp_id <= ptr;
          rsp_data <= m_rd_we ? m_data_read : '0;
          rsp_err <= 1'b0;
          state <= RESPOND;
        end else seen <= seen | m_busy;
        RESPOND: state <= IDLE;
        default: begin
          m_enable <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
